// File: rtl/bram_rmw_adapter.sv
// rtl/bram_rmw_adapter.sv - core req/gnt/rvalid port to single-port BRAM, read-modify-write for byte-enabled stores
module bram_rmw_adapter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RAM_DEPTH  = 1024,
  parameter  int ADDR_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int BW         = $clog2(RAM_DEPTH - 1),
  localparam int OFF        = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [NB-1:0]         be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [BW-1:0]         bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i
);

  typedef enum logic [0:0] {IDLE, MERGE} state_e;

  state_e                state_q, state_d;
  logic                  rvalid_q, rvalid_d;
  logic                  resp_is_read_q, resp_is_read_d;
  logic [BW-1:0]         cap_addr_q, cap_addr_d;
  logic [NB-1:0]         cap_be_q, cap_be_d;
  logic [DATA_WIDTH-1:0] cap_wdata_q, cap_wdata_d;

  logic [BW-1:0] word_idx;
  logic          unused_addr;

  // Upper address bits wrap silently and byte-offset bits carry no meaning.
  assign word_idx    = addr_i[OFF +: BW];
  assign unused_addr = ^addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rvalid_q       <= 1'b0;
      resp_is_read_q <= 1'b0;
      cap_addr_q     <= '0;
      cap_be_q       <= '0;
      cap_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      rvalid_q       <= rvalid_d;
      resp_is_read_q <= resp_is_read_d;
      cap_addr_q     <= cap_addr_d;
      cap_be_q       <= cap_be_d;
      cap_wdata_q    <= cap_wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rvalid_d       = 1'b0;
    resp_is_read_d = 1'b0;
    cap_addr_d     = cap_addr_q;
    cap_be_d       = cap_be_q;
    cap_wdata_d    = cap_wdata_q;
    gnt_o          = 1'b0;
    bram_en_o      = 1'b0;
    bram_we_o      = 1'b0;
    bram_addr_o    = '0;
    bram_din_o     = '0;

    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          rvalid_d       = 1'b1;
          resp_is_read_d = !we_i;
          if (!we_i) begin
            bram_en_o   = 1'b1;
            bram_addr_o = word_idx;
          end else if (&be_i) begin
            bram_en_o   = 1'b1;
            bram_we_o   = 1'b1;
            bram_addr_o = word_idx;
            bram_din_o  = wdata_i;
          end else if (|be_i) begin
            // Fetch the old word now; the merge happens next cycle when douta is valid.
            bram_en_o   = 1'b1;
            bram_addr_o = word_idx;
            rvalid_d    = 1'b0;
            cap_addr_d  = word_idx;
            cap_be_d    = be_i;
            cap_wdata_d = wdata_i;
            state_d     = MERGE;
          end
        end
      end
      MERGE: begin
        bram_en_o   = 1'b1;
        bram_we_o   = 1'b1;
        bram_addr_o = cap_addr_q;
        for (int b = 0; b < NB; b++) begin
          bram_din_o[b*8 +: 8] = cap_be_q[b] ? cap_wdata_q[b*8 +: 8] : bram_dout_i[b*8 +: 8];
        end
        rvalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (rvalid_q && resp_is_read_q) ? bram_dout_i : '0;

endmodule

// File: tb/tb_bram_rmw_adapter.sv
// tb/tb_bram_rmw_adapter.sv - self-checking bench for bram_rmw_adapter with a behavioural BRAM and word-array model
module tb_bram_rmw_adapter;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;
  localparam int NB    = DW / 8;
  localparam int BW    = $clog2(DEPTH - 1);

  logic          clk, rst_n;
  logic          req, gnt, we, rvalid, bram_en, bram_we;
  logic [AW-1:0] addr;
  logic [NB-1:0] be;
  logic [DW-1:0] wdata, rdata, bram_din, bram_dout;
  logic [BW-1:0] bram_addr;

  bram_rmw_adapter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .bram_en_o(bram_en),
    .bram_we_o(bram_we), .bram_addr_o(bram_addr), .bram_din_o(bram_din), .bram_dout_i(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [DW-1:0] bram_mem [DEPTH];
  int          wr_cnt;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bram_mem[bram_addr] <= bram_din;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bram_dout <= bram_mem[bram_addr];
      end
    end
  end

  int          total, bad, rv_cnt;
  bit [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / NB) % DEPTH);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 want no response pending");
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_idle", rdata, '0);
      end
    end
  end

  task automatic idle();
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [NB-1:0] b,
                        input logic [DW-1:0] d, input bit commit, input bit use_ovr,
                        input logic [DW-1:0] ovr, output int waits);
    logic [DW-1:0] e;
    int i;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    waits = 0;
    while (!gnt && waits < 8) begin
      @(posedge clk);
      #2;
      waits++;
    end
    if (!gnt) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: got no gnt want gnt within 8 cycles");
    end else if (commit) begin
      i = widx(a);
      if (!w) begin
        e = use_ovr ? ovr : ref_mem[i];
      end else begin
        e = '0;
        for (int k = 0; k < NB; k++) if (b[k]) ref_mem[i][k*8 +: 8] = d[k*8 +: 8];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [NB-1:0] b;
    logic [DW-1:0] d;
    int            exp_wait;
  } vec_t;

  vec_t vecs[11];
  int   w1, w2, c0, r0;
  bit   prev_partial, gap;

  initial begin
    vecs[0]  = '{1'b1, 32'h14,   4'hF, 32'hDEADBEEF, 0};
    vecs[1]  = '{1'b0, 32'h14,   4'h0, 32'hDEADBEEF, 0};
    vecs[2]  = '{1'b1, 32'h20,   4'hF, 32'hCAFEF00D, 0};
    vecs[3]  = '{1'b0, 32'h20,   4'h0, 32'hCAFEF00D, 0};
    vecs[4]  = '{1'b1, 32'h14,   4'h3, 32'h12345678, 0};
    vecs[5]  = '{1'b0, 32'h14,   4'h0, 32'hDEAD5678, 1};
    vecs[6]  = '{1'b1, 32'h22,   4'h8, 32'hAA000000, 0};
    vecs[7]  = '{1'b1, 32'h20,   4'h1, 32'h000000BB, 1};
    vecs[8]  = '{1'b0, 32'h21,   4'h0, 32'hAAFEF0BB, 1};
    vecs[9]  = '{1'b1, 32'h14,   4'h0, 32'hFFFFFFFF, 0};
    vecs[10] = '{1'b0, 32'h1014, 4'h0, 32'hDEAD5678, 0};

    rst_n = 1'b0;
    idle();
    step(3);
    check("rst_gnt", {31'b0, gnt}, '0);
    check("rst_rvalid", {31'b0, rvalid}, '0);
    check("rst_rdata", rdata, '0);
    check("rst_bram_en", {31'b0, bram_en}, '0);
    check("rst_bram_we", {31'b0, bram_we}, '0);
    rst_n = 1'b1;
    step(1);

    foreach (vecs[i]) begin
      do_req(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, 1'b1, !vecs[i].w, vecs[i].d, w1);
      check($sformatf("vec%0d_wait", i), 32'(w1), 32'(vecs[i].exp_wait));
    end
    idle();
    step(3);

    // Partial write: BRAM write happens in the stall cycle, response one cycle later.
    do_req(1'b1, 32'h28, 4'b0110, 32'h11223344, 1'b1, 1'b0, '0, w1);
    idle();
    #1;
    check("merge_en", {31'b0, bram_en}, 32'd1);
    check("merge_we", {31'b0, bram_we}, 32'd1);
    check("merge_din", bram_din, 32'h00223300);
    check("merge_rvalid_n1", {31'b0, rvalid}, '0);
    step(1);
    check("merge_rvalid_n2", {31'b0, rvalid}, 32'd1);
    do_req(1'b0, 32'h28, '0, '0, 1'b1, 1'b1, 32'h00223300, w1);
    idle();
    step(3);

    r0 = rv_cnt;
    do_req(1'b1, 32'h40, 4'b1000, 32'h77000000, 1'b1, 1'b0, '0, w1);
    do_req(1'b1, 32'h40, 4'b0001, 32'h00000099, 1'b1, 1'b0, '0, w2);
    idle();
    step(3);
    check("b2b_first_wait", 32'(w1), 0);
    check("b2b_second_wait", 32'(w2), 1);
    check("b2b_rvalid_count", 32'(rv_cnt - r0), 2);
    do_req(1'b0, 32'h40, '0, '0, 1'b1, 1'b1, 32'h77000099, w1);
    idle();
    step(3);

    do_req(1'b1, 32'h30, 4'hF, 32'h55AA55AA, 1'b1, 1'b0, '0, w1);
    idle();
    step(3);
    c0 = wr_cnt;
    do_req(1'b1, 32'h30, 4'b0001, 32'h000000FF, 1'b0, 1'b0, '0, w1);
    idle();
    rst_n = 1'b0;
    #1;
    check("rstmerge_rvalid", {31'b0, rvalid}, '0);
    check("rstmerge_bram_we", {31'b0, bram_we}, '0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rstmerge_no_write", 32'(wr_cnt - c0), 0);
    do_req(1'b0, 32'h30, '0, '0, 1'b1, 1'b1, 32'h55AA55AA, w1);
    idle();
    step(3);

    c0 = wr_cnt;
    do_req(1'b1, 32'h44, 4'h0, 32'h12345678, 1'b1, 1'b0, '0, w1);
    idle();
    step(3);
    check("be0_no_write", 32'(wr_cnt - c0), 0);

    prev_partial = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra;
      logic [NB-1:0] rb;
      bit rw;
      gap = ($urandom % 3) == 0;
      if (gap) begin
        idle();
        step($urandom_range(1, 2));
      end
      rw = $urandom % 2;
      ra = ($urandom & 32'hFFFF_F000) | (($urandom % 16) << 2) | ($urandom % 4);
      case ($urandom % 4)
        0: rb = 4'hF;
        1: rb = 4'h0;
        default: rb = 4'($urandom);
      endcase
      do_req(rw, ra, rb, $urandom, 1'b1, 1'b0, '0, w1);
      check($sformatf("rand%0d_wait", n), 32'(w1), (prev_partial && !gap) ? 32'd1 : 32'd0);
      prev_partial = rw && (rb != 4'h0) && (rb != 4'hF);
    end
    idle();
    step(4);
    check("drain_pending", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
